// File: rtl/elevator_scheduler_if.sv
// Bundles the call inputs and the stepping/status outputs of the scheduler.
// master drives calls and emergency; slave is the scheduler itself.
interface elevator_scheduler_if;
  logic [15:0] i_call_req;
  logic        i_emg;
  logic        o_step;
  logic        o_updn;
  logic [3:0]  o_floor;
  logic        o_door_open;
  logic        o_moving;
  logic [15:0] o_pending;

  modport master (
    output i_call_req, i_emg,
    input  o_step, o_updn, o_floor, o_door_open, o_moving, o_pending
  );

  modport slave (
    input  i_call_req, i_emg,
    output o_step, o_updn, o_floor, o_door_open, o_moving, o_pending
  );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler for the 4-bit floor counter: latches calls, paces step
// strobes, mirrors the counter position, times the door, handles emergency descent.
module elevator_scheduler #(
  parameter int TRAVEL_CYCLES = 3,
  parameter int DOOR_CYCLES   = 4,
  parameter int SKIP_FLOOR    = 13
) (
  input logic clk,
  input logic rst,
  elevator_scheduler_if.slave bus
);
  // state  | meaning
  // IDLE   | parked, door closed, picking a direction
  // TRAVEL | counting down to the next step strobe
  // ARRIVE | one cycle after a step: stop, continue or park
  // DOOR   | door open, dwell timer running
  // EMG    | calls dropped, descending to floor 0, door open there
  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAVEL,
    S_ARRIVE,
    S_DOOR,
    S_EMG
  } state_t;

  localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES);
  // The ARRIVE cycle counts toward the spacing between consecutive steps.
  localparam logic [TW-1:0] RELOAD_LD = TW'((TRAVEL_CYCLES > 1) ? TRAVEL_CYCLES - 1 : 1);

  localparam logic [3:0]  SKIP_CODE = 4'(SKIP_FLOOR);
  localparam logic [15:0] SKIP_MASK = 16'(1) << SKIP_FLOOR;

  state_t        r_state;
  logic [3:0]    r_floor;
  logic          r_updn;
  logic [15:0]   r_pending;
  logic [TW-1:0] r_timer;

  state_t        w_state_n;
  logic [3:0]    w_floor_n;
  logic          w_updn_n;
  logic [15:0]   w_pending_n;
  logic [TW-1:0] w_timer_n;
  logic          w_step;
  logic          w_door_clr;
  logic          w_above;
  logic          w_below;
  logic          w_ahead;
  logic          w_behind;
  logic          w_here_pend;
  logic          w_here_call;
  logic [15:0]   w_set;

  function automatic logic [3:0] next_floor(input logic [3:0] f, input logic up);
    logic [3:0] n;
    n = up ? f + 4'd1 : f - 4'd1;
    if (n == SKIP_CODE) n = up ? n + 4'd1 : n - 4'd1;
    return n;
  endfunction

  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) > r_floor) w_above = w_above | r_pending[i];
      if (4'(i) < r_floor) w_below = w_below | r_pending[i];
    end
  end

  assign w_ahead     = r_updn ? w_above : w_below;
  assign w_behind    = r_updn ? w_below : w_above;
  assign w_here_pend = r_pending[r_floor];
  assign w_here_call = bus.i_call_req[r_floor];

  always_comb begin
    w_state_n  = r_state;
    w_floor_n  = r_floor;
    w_updn_n   = r_updn;
    w_timer_n  = r_timer;
    w_step     = 1'b0;
    w_door_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_here_pend || w_here_call) begin
          w_state_n  = S_DOOR;
          w_timer_n  = DOOR_LD;
          w_door_clr = 1'b1;
        end else if (w_ahead) begin
          w_state_n = S_TRAVEL;
          w_timer_n = TRAVEL_LD;
        end else if (w_behind) begin
          w_updn_n  = ~r_updn;
          w_state_n = S_TRAVEL;
          w_timer_n = TRAVEL_LD;
        end
      end
      S_TRAVEL: begin
        if (r_timer == TIMER_ONE) begin
          w_step    = 1'b1;
          w_floor_n = next_floor(r_floor, r_updn);
          w_state_n = S_ARRIVE;
        end else begin
          w_timer_n = r_timer - TIMER_ONE;
        end
      end
      S_ARRIVE: begin
        if (w_here_pend) begin
          w_state_n  = S_DOOR;
          w_timer_n  = DOOR_LD;
          w_door_clr = 1'b1;
        end else if (w_ahead) begin
          w_state_n = S_TRAVEL;
          w_timer_n = RELOAD_LD;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_DOOR: begin
        if (w_here_call) begin
          w_timer_n = DOOR_LD;
        end else if (r_timer == TIMER_ONE) begin
          w_state_n = S_IDLE;
        end else begin
          w_timer_n = r_timer - TIMER_ONE;
        end
      end
      S_EMG: begin
        // A strobe already due is still issued so the mirror tracks the counter.
        if (r_floor != 4'd0) begin
          if (r_timer == TIMER_ONE) begin
            w_step    = 1'b1;
            w_floor_n = next_floor(r_floor, 1'b0);
            w_timer_n = TRAVEL_LD;
          end else begin
            w_timer_n = r_timer - TIMER_ONE;
          end
        end
        if (!bus.i_emg) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (bus.i_emg && r_state != S_EMG) begin
      w_state_n  = S_EMG;
      w_updn_n   = 1'b0;
      w_timer_n  = TRAVEL_LD;
      w_door_clr = 1'b0;
    end
  end

  always_comb begin
    w_set = bus.i_call_req & ~SKIP_MASK;
    if (r_state == S_IDLE || r_state == S_DOOR) w_set[r_floor] = 1'b0;
    w_pending_n = r_pending | w_set;
    if (w_door_clr) w_pending_n[r_floor] = 1'b0;
    if (r_state == S_EMG || w_state_n == S_EMG) w_pending_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_floor   <= 4'd0;
      r_updn    <= 1'b1;
      r_pending <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_floor   <= w_floor_n;
      r_updn    <= w_updn_n;
      r_pending <= w_pending_n;
      r_timer   <= w_timer_n;
    end
  end

  assign bus.o_step      = w_step;
  assign bus.o_updn      = r_updn;
  assign bus.o_floor     = r_floor;
  assign bus.o_pending   = r_pending;
  assign bus.o_door_open = (r_state == S_DOOR) || (r_state == S_EMG && r_floor == 4'd0);
  assign bus.o_moving    = (r_state == S_TRAVEL) || (r_state == S_EMG && r_floor != 4'd0);
endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Call scheduler and sequencer for the 4-bit elevator floor counter.
- Latches per-floor call requests and chooses the travel direction with a SCAN policy (keep direction while calls remain ahead).
- Paces travel by issuing one-cycle step strobes plus updn to the counter, mirrors the counter position internally, and times the door.
- On emergency it drops all calls and descends to floor 0.
- Floor code 13 does not exist; motion goes 12<->14 directly.

Parameters:
- TRAVEL_CYCLES, 3: cycles between successive step strobes while moving (>=1).
- DOOR_CYCLES, 4: cycles door_open stays high per stop (>=1).
- SKIP_FLOOR, 13: floor code that does not exist; calls to it are ignored, and travel jumps over it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- call_req  in  16  per-floor call pulses; bit n = floor n.
- emg  in  1  emergency, level-sensitive.
- step  out  1  one-cycle strobe; the floor counter advances one floor in direction updn.
- updn  out  1  direction, 1 = up; valid whenever step = 1; holds last direction otherwise.
- floor  out  4  scheduler's mirror of the current floor.
- door_open  out  1  door open.
- moving  out  1  high in TRAVEL and in EMG while above floor 0.
- pending  out  16  latched outstanding calls.

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, floor 0, updn 1, pending 0, step 0, door_open 0, moving 0, timer 0.
- Call latching:
  - A call_req bit is ORed into pending each cycle.
  - The SKIP_FLOOR bit is always masked; pending[SKIP_FLOOR] is always 0.
  - A call for the current floor while in IDLE or DOOR is not latched. It opens the door or restarts the door timer instead.
- Next-floor arithmetic:
  - Up: floor+1, except 12 -> 14.
  - Down: floor-1, except 14 -> 12.
  - No step above 15 or below 0 is ever issued.
- "Ahead" means pending bits strictly above floor when updn = 1, strictly below when updn = 0.
- State IDLE:
  - emg -> EMG.
  - pending[floor] -> DOOR.
  - Else, if calls are ahead -> TRAVEL, direction kept.
  - Else, if calls exist behind -> flip updn, then TRAVEL.
  - Else stay in IDLE.
  - TRAVEL entry loads timer = TRAVEL_CYCLES.
- State TRAVEL:
  - The timer decrements each cycle.
  - When the timer reaches 1: step = 1 that cycle, floor updates to the next floor on the following edge, and the state goes to ARRIVE.
  - Latency from IDLE->TRAVEL transition to step: TRAVEL_CYCLES cycles.
- State ARRIVE (1 cycle, step = 0):
  - pending[floor] -> DOOR.
  - Else, if calls are ahead -> TRAVEL with timer reloaded.
  - Else -> IDLE.
- State DOOR:
  - Entry clears pending[floor] and loads timer = DOOR_CYCLES.
  - door_open = 1 throughout.
  - When the timer expires -> IDLE, and door_open falls the same edge.
- State EMG:
  - Entered from any state when emg = 1, evaluated on the next clk edge; emg has priority over every other condition.
  - Entry clears pending and forces door_open = 0 immediately, including mid-DOOR. Entry also sets updn = 0 and loads timer = TRAVEL_CYCLES.
  - call_req is ignored while in EMG.
  - Above floor 0: issue a step every TRAVEL_CYCLES cycles, descending.
  - At floor 0: no steps, and door_open = 1 held while emg = 1.
  - emg deasserted -> IDLE with door_open = 0, from any floor; a partial descent resumes normal service.
- Simultaneous events:
  - Set and clear of the same pending bit in one cycle: the clear wins. The call is being served by the open door.
  - emg and call_req in the same cycle: the call is dropped.
- Reset mid-operation returns all outputs to their reset values immediately; no step is issued.

Test Plan:
- Reset, then call_req = 16'h0020 pulse -> updn = 1; 5 step strobes, each 3 cycles apart; floor 0->5; door_open high 4 cycles; pending returns to 0.
- At floor 12, call_req bit 15 -> steps give floor 14 then 15 (13 skipped); a call_req bit 13 pulse leaves pending = 0.
- At floor 5 travelling up with pending bits 8 and 2 -> stops at 8 first, then updn flips to 0 and it stops at 2.
- At floor 7 in DOOR with pending bit 10, assert emg -> door_open drops next edge, pending = 0, 7 down-steps, then floor 0 with door_open = 1; release emg -> IDLE, door_open = 0.
- In IDLE at floor 3, call_req bit 3 -> DOOR without any step. Repeat bit 3 during DOOR -> door timer restarts, and door stays open 4 more cycles.
- Assert rst during TRAVEL -> floor, pending, step, door_open = 0 and updn = 1 immediately; no step follows.
